// File: rtl/modn_pwm_gen.sv
// modn_pwm_gen: registered PWM and period tick derived from a mod-N count, with a double-buffered duty.
// Define PWM_DEADTIME_EN to get complementary pwm_h/pwm_l outputs with DEAD cycles of dead-time.
module modn_pwm_gen #(
  parameter int N     = 12,
  parameter int width = 4,
  parameter int DEAD  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] count,
  input  logic [width:0]   duty,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             period_tick
);
  localparam logic [width:0]   DUTY_MAX = (width+1)'(N);
  localparam logic [width-1:0] CNT_LAST = width'(N-1);

  typedef enum logic {EMPTY, FULL} slot_e;

  slot_e          slot_q, slot_d;
  logic [width:0] pend_q, pend_d;
  logic [width:0] act_q, act_d;
  logic           raw_q, raw_d;
  logic           tick_q;
  logic           wrap, accept;

  function automatic logic [width:0] clamp_duty(input logic [width:0] d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

  assign wrap       = (count == CNT_LAST);
  assign duty_ready = (slot_q == EMPTY);
  assign accept     = duty_valid && duty_ready;
  assign raw_d      = ({1'b0, count} < act_q);

  // A full slot cannot accept, so commit and accept never coincide.
  always_comb begin
    slot_d = slot_q;
    pend_d = pend_q;
    act_d  = act_q;
    if (slot_q == FULL && wrap) begin
      act_d  = pend_q;
      slot_d = EMPTY;
    end else if (accept) begin
      pend_d = clamp_duty(duty);
      slot_d = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= EMPTY;
      act_q  <= '0;
      raw_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      act_q  <= act_d;
      raw_q  <= raw_d;
      tick_q <= wrap;
    end
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  assign period_tick = tick_q;

`ifdef PWM_DEADTIME_EN
  localparam int              DT_W    = $clog2(DEAD+1);
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEAD);
  localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);

  logic [DT_W-1:0] dt_q, dt_d;
  logic            h_q, h_d, l_q, l_d;

  // Any raw edge drops both sides and restarts the dead-time; the new side
  // turns on once the counter has run out.
  always_comb begin
    dt_d = dt_q;
    h_d  = h_q;
    l_d  = l_q;
    if (raw_d != raw_q) begin
      dt_d = DT_LOAD;
      h_d  = 1'b0;
      l_d  = 1'b0;
    end else if (dt_q > DT_ONE) begin
      dt_d = dt_q - DT_ONE;
    end else begin
      dt_d = '0;
      h_d  = raw_q;
      l_d  = !raw_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dt_q <= DT_LOAD;
      h_q  <= 1'b0;
      l_q  <= 1'b0;
    end else begin
      dt_q <= dt_d;
      h_q  <= h_d;
      l_q  <= l_d;
    end
  end

  assign pwm_h = h_q;
  assign pwm_l = l_q;
`else
  assign pwm_h = raw_q;
  assign pwm_l = 1'b0;
`endif

endmodule
